layer1_reader: RTL and testbench

- Consumer end of the layer-1 activation interface.
- Waits for the packed 256-bit activation vector and its done flag from the layer-1 accumulator, then snapshots the vector.
- Streams the vector one signed 8-bit activation per transfer over a valid/ready handshake into the layer-2 neuron datapath.
- Replays the full vector once per layer-2 neuron (NUM_PASSES times), with optional ReLU applied on the way out.

---
 rtl/layer1_reader.sv | 142 ++++++++++++++
 tb/tb_layer1_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/layer1_reader.sv
// layer1_reader: snapshots the layer-1 activation vector on the rising edge
// of vec_done and replays it NUM_PASSES times over a valid/ready stream.
module layer1_reader #(
    parameter int NUM_IN     = 32,
    parameter int DATA_W     = 8,
    parameter int NUM_PASSES = 10,
    parameter int RELU       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN*DATA_W-1:0]   vec_in,
    input  logic                       vec_done,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       dout_last,
    output logic [$clog2(NUM_IN)-1:0]  elem_idx,
    output logic [7:0]                 pass_idx,
    output logic                       busy,
    output logic                       all_done
);

    localparam int EW = $clog2(NUM_IN);
    localparam logic [EW-1:0] LAST_E = EW'(NUM_IN - 1);
    localparam logic [7:0]    LAST_P = 8'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_IN*DATA_W-1:0] shadow_q, shadow_d;
    logic [EW-1:0]            elem_q, elem_d;
    logic [7:0]               pass_q, pass_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     vec_done_q;

    logic                     start;
    logic                     xfer;
    logic                     at_last_e;
    logic                     at_last_p;
    logic [DATA_W-1:0]        elems [NUM_IN];
    logic [DATA_W-1:0]        e;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_el
        assign elems[i] = shadow_q[i*DATA_W +: DATA_W];
    end

    assign start     = vec_done & ~vec_done_q;
    assign xfer      = valid_q & dout_ready;
    assign at_last_e = (elem_q == LAST_E);
    assign at_last_p = (pass_q == LAST_P);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            elem_q     <= '0;
            pass_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vec_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            elem_q     <= elem_d;
            pass_q     <= pass_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vec_done_q <= vec_done;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        elem_d   = elem_q;
        pass_d   = pass_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = vec_in;
                    elem_d   = '0;
                    pass_d   = '0;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                // Pass wrap has no bubble: valid stays high across it
                if (xfer) begin
                    if (!at_last_e) begin
                        elem_d = elem_q + EW'(1);
                    end else if (!at_last_p) begin
                        elem_d = '0;
                        pass_d = pass_q + 8'd1;
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        e = elems[elem_q];
        if (!valid_q) begin
            dout = '0;
        end else if ((RELU != 0) && e[DATA_W-1]) begin
            dout = '0;
        end else begin
            dout = e;
        end
    end

    assign dout_valid = valid_q;
    assign dout_last  = valid_q & at_last_e;
    assign elem_idx   = elem_q;
    assign pass_idx   = pass_q;
    assign busy       = busy_q;
    assign all_done   = done_q;

endmodule

// File: tb/tb_layer1_reader.sv
// Bench for layer1_reader: two instances (ReLU on / off) share stimulus
// and are checked against an element/pass model of the replayed stream.
module tb_layer1_reader;

    localparam int NI = 32;
    localparam int NP = 10;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NI*DW-1:0] vec_in;
    logic             vec_done;
    logic             dout_ready;

    logic [DW-1:0]    dout1, dout0;
    logic             valid1, valid0;
    logic             last1, last0;
    logic [4:0]       elem1, elem0;
    logic [7:0]       pass1, pass0;
    logic             busy1, busy0;
    logic             done1, done0;

    int  total = 0;
    int  bad   = 0;
    byte exp_vec [NI];

    always #5 clk = ~clk;

    layer1_reader #(.NUM_IN(NI), .DATA_W(DW), .NUM_PASSES(NP), .RELU(1)) dut (
        .clk(clk), .rst_n(rst_n), .vec_in(vec_in), .vec_done(vec_done),
        .dout(dout1), .dout_valid(valid1), .dout_ready(dout_ready),
        .dout_last(last1), .elem_idx(elem1), .pass_idx(pass1),
        .busy(busy1), .all_done(done1)
    );

    layer1_reader #(.NUM_IN(NI), .DATA_W(DW), .NUM_PASSES(NP), .RELU(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .vec_in(vec_in), .vec_done(vec_done),
        .dout(dout0), .dout_valid(valid0), .dout_ready(dout_ready),
        .dout_last(last0), .elem_idx(elem0), .pass_idx(pass0),
        .busy(busy0), .all_done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ref_out(input int k, input bit relu);
        int v;
        v = exp_vec[k % NI];
        if (relu && v < 0) v = 0;
        return 8'(v);
    endfunction

    task automatic load_vec(input int kind);
        for (int i = 0; i < NI; i++) begin
            if (kind == 0) exp_vec[i] = byte'(i);
            else exp_vec[i] = byte'($urandom_range(255));
        end
        if (kind == 1) begin
            exp_vec[0] = byte'(8'h80);
            exp_vec[1] = byte'(8'hFF);
            exp_vec[2] = byte'(8'h7F);
            exp_vec[3] = byte'(8'h05);
        end
        for (int i = 0; i < NI; i++) vec_in[i*DW +: DW] = exp_vec[i];
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, valid1}, 32'd0);
        chk({tag, "_valid0"}, {31'd0, valid0}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy1}, 32'd0);
        chk({tag, "_dout"}, {24'd0, dout1}, 32'd0);
        chk({tag, "_last"}, {31'd0, last1}, 32'd0);
        chk({tag, "_elem"}, {27'd0, elem1}, 32'd0);
        chk({tag, "_pass"}, {24'd0, pass1}, 32'd0);
    endtask

    // mode 0: plain, 1: writer disturbance mid pass 3, 2: reset at pass 5 elem 17
    task automatic run_stream(input int duty, input int mode,
                              input int budget, output int cyc_out);
        int k;
        int cyc;
        int ph;
        bit stop;
        k = 0;
        cyc = 0;
        ph = 0;
        stop = 1'b0;
        cyc_out = -1;
        while (!stop) begin
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                total++;
                bad++;
                $error("FAIL timeout observed_xfers=%0d expected=%0d", k, NI*NP);
                stop = 1'b1;
            end else if (k == NI*NP) begin
                chk("end_valid", {31'd0, valid1}, 32'd0);
                chk("end_done", {31'd0, done1}, 32'd1);
                chk("end_done0", {31'd0, done0}, 32'd1);
                chk("end_busy", {31'd0, busy1}, 32'd0);
                chk("end_dout", {24'd0, dout1}, 32'd0);
                chk("end_last", {31'd0, last1}, 32'd0);
                cyc_out = cyc;
                stop = 1'b1;
            end else begin
                chk("valid", {31'd0, valid1}, 32'd1);
                chk("dout_relu", {24'd0, dout1}, {24'd0, ref_out(k, 1'b1)});
                chk("dout_raw", {24'd0, dout0}, {24'd0, ref_out(k, 1'b0)});
                chk("elem", {27'd0, elem1}, 32'(k % NI));
                chk("pass", {24'd0, pass1}, 32'(k / NI));
                chk("last", {31'd0, last1}, {31'd0, (k % NI) == NI - 1});
                chk("busy", {31'd0, busy1}, 32'd1);
                chk("done_early", {31'd0, done1}, 32'd0);
                if (mode == 2 && k == 5*NI + 17) begin
                    rst_n = 1'b0;
                    vec_done = 1'b0;
                    @(negedge clk);
                    check_idle("midrst");
                    chk("midrst_done", {31'd0, done1}, 32'd0);
                    rst_n = 1'b1;
                    cyc_out = cyc;
                    stop = 1'b1;
                end else begin
                    if (mode == 1 && k >= 3*NI + 10 && ph == 0) begin
                        for (int i = 0; i < NI; i++) vec_in[i*DW +: DW] = 8'h11;
                        vec_done = 1'b0;
                        ph = 1;
                    end else if (ph == 1) begin
                        vec_done = 1'b1;
                        ph = 2;
                    end
                    dout_ready = ($urandom_range(99) < duty);
                    if (dout_ready) k++;
                end
            end
        end
    endtask

    task automatic hold_reset(input bit keep_done);
        @(negedge clk);
        rst_n = 1'b0;
        vec_done = keep_done;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        vec_done = 1'b0;
        dout_ready = 1'b0;
        vec_in = '0;
        repeat (2) @(negedge clk);
        check_idle("rst");
        chk("rst_done", {31'd0, done1}, 32'd0);

        // Ramp at full rate, cycle-exact completion
        load_vec(0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_valid", {31'd0, valid1}, 32'd0);
        vec_done = 1'b1;
        run_stream(100, 0, 400, cyc);
        chk("ramp_done_cycle", 32'(cyc), 32'd321);

        // Post-done: a fresh vec_done edge is ignored
        vec_done = 1'b0;
        @(negedge clk);
        vec_done = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_valid", {31'd0, valid1}, 32'd0);
            chk("post_done", {31'd0, done1}, 32'd1);
        end

        // ReLU patterns under 30% backpressure; vec_done high at reset release
        hold_reset(1'b1);
        load_vec(1);
        rst_n = 1'b1;
        run_stream(30, 0, 5000, cyc);

        // Snapshot isolation mid pass 3
        hold_reset(1'b0);
        load_vec(2);
        rst_n = 1'b1;
        @(negedge clk);
        vec_done = 1'b1;
        run_stream(100, 1, 400, cyc);

        // Reset mid-stream then restart on a fresh edge
        hold_reset(1'b0);
        load_vec(2);
        rst_n = 1'b1;
        @(negedge clk);
        vec_done = 1'b1;
        run_stream(60, 2, 2000, cyc);
        repeat (2) begin
            @(negedge clk);
            chk("rearm_valid", {31'd0, valid1}, 32'd0);
        end
        vec_done = 1'b1;
        run_stream(100, 0, 400, cyc);
        chk("restart_done_cycle", 32'(cyc), 32'd321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
